// File: rtl/seq_adder_pkg.sv
// Shared types for the sequential N-bit adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_adder_nbit_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice used by seq_adder_nbit.
// c_msb is the carry into the top bit, used for signed overflow on the last slice.
module adder_chunk #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    // Ripple the carry through each bit of the slice.
    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout  = carry[CHUNK];
        c_msb = carry[CHUNK - 1];
    end

endmodule

// File: rtl/seq_adder_nbit.sv
// Multi-cycle N-bit adder: adds CHUNK bits per clock through a registered carry,
// with a start/busy/done handshake. Result registers update only on entry to DONE.
// Optional macro ADDER_SUB_EN adds a sub port selecting a - b.
import seq_adder_pkg::*;

module seq_adder_nbit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             carry_reg;
    logic [CW-1:0]    cnt;
    logic             last;

    logic [WIDTH-1:0] b_load;
    logic             c_load;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;

`ifdef ADDER_SUB_EN
    // Subtraction is a + ~b + 1: invert B and force the carry in.
    assign b_load = sub ? ~b : b;
    assign c_load = sub | carry_in;
`else
    assign b_load = b;
    assign c_load = carry_in;
`endif

    assign a_chunk = a_reg[cnt * CHUNK +: CHUNK];
    assign b_chunk = b_reg[cnt * CHUNK +: CHUNK];
    assign last    = (cnt == CW'(NCHUNK - 1));

    adder_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_reg),
        .sum  (chunk_sum),
        .cout (chunk_cout),
        .c_msb(chunk_cmsb)
    );

    // Partial sum with the current slice merged in; lets the final slice reach sum on the same edge.
    always_comb begin
        psum_next                       = psum;
        psum_next[cnt * CHUNK +: CHUNK] = chunk_sum;
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = BUSY;
            BUSY: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, chunk-serial accumulation and result load.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            psum      <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    a_reg     <= a;
                    b_reg     <= b_load;
                    carry_reg <= c_load;
                    psum      <= '0;
                    cnt       <= '0;
                end
                BUSY: begin
                    psum      <= psum_next;
                    carry_reg <= chunk_cout;
                    cnt       <= cnt + 1'b1;
                    if (last) begin
                        sum       <= psum_next;
                        carry_out <= chunk_cout;
                        overflow  <= chunk_cout ^ chunk_cmsb;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_adder_nbit.sv
// Directed testbench for seq_adder_nbit (WIDTH=8, CHUNK=2).
// Define ADDER_SUB_EN to also exercise the subtract mode.
module tb_seq_adder_nbit;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
`ifdef ADDER_SUB_EN
    logic       sub;
`endif
    logic [7:0] sum;
    logic       carry_out;
    logic       overflow;
    logic       busy;
    logic       done;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    seq_adder_nbit #(
        .WIDTH(8),
        .CHUNK(2)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
`ifdef ADDER_SUB_EN
        .sub      (sub),
`endif
        .sum      (sum),
        .carry_out(carry_out),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation from IDLE, scramble inputs while busy, check latency and result.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic ts,
                          input logic [7:0] es, input logic ec, input logic eo);
        int unsigned edges;
        int unsigned busy_cnt;
        a        = ta;
        b        = tb;
        carry_in = tc;
`ifdef ADDER_SUB_EN
        sub      = ts;
`else
        if (ts) $display("note: sub requested without ADDER_SUB_EN");
`endif
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        edges    = 0;
        busy_cnt = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cnt++;
            a        = ~ta;
            b        = ~tb;
            carry_in = ~tc;
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, edges, 4);
        check({tag, "_busy_cycles"}, busy_cnt, 4);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, carry_out, ec);
        check({tag, "_ovf"}, overflow, eo);
        check({tag, "_busy_at_done"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_sum_held"}, sum, es);
    endtask

    initial begin
        logic [7:0] held;
        n_rst    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
`ifdef ADDER_SUB_EN
        sub      = 1'b0;
`endif
        #2;
        check("rst_sum",  sum, 0);
        check("rst_cout", carry_out, 0);
        check("rst_ovf",  overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #20 n_rst = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        run_op("t1",   8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op("t2a",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("t2b",  8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("t3b",  8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op("t3a",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        // Abort during the second busy cycle.
        a        = 8'h35;
        b        = 8'h4A;
        carry_in = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", busy, 1);
        n_rst = 1'b0;
        #1;
        check("abort_sum",  sum, 0);
        check("abort_cout", carry_out, 0);
        check("abort_ovf",  overflow, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        #1 n_rst = 1'b1;
        @(posedge clk); #1;
        check("abort_idle", busy, 0);
        run_op("t4", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

        // start held high with new operands every cycle: accepts at edges 0, 6, 12.
        for (int e = 0; e < 18; e++) begin
            a        = 8'(8'h10 + e);
            b        = 8'(8'h20 + 2 * e);
            carry_in = 1'b0;
            start    = 1'b1;
            @(posedge clk); #1;
            if (e < 4)       held = 8'h03;
            else if (e < 10) held = 8'h30;
            else if (e < 16) held = 8'h42;
            else             held = 8'h54;
            check($sformatf("t5_done_e%0d", e), done, (e == 4 || e == 10 || e == 16) ? 1 : 0);
            check($sformatf("t5_sum_e%0d", e), sum, held);
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("t5_settled_busy", busy, 0);

`ifdef ADDER_SUB_EN
        run_op("t6a", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("t6b", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
